// File: rtl/fir_l2_pkg.sv
// Shared definitions for the L=2 fast-FIR front/back ends: default widths, serializer
// state encoding and the rescale/narrow helpers used on every output sample.
package fir_l2_pkg;

    localparam int unsigned PAIR_WIDTH_DEF = 32'd64;
    localparam int unsigned OUT_WIDTH_DEF  = 32'd16;
    localparam int unsigned SHIFT_DEF      = 32'd30;
    localparam int unsigned FIFO_DEPTH_DEF = 32'd4;

    // Working width for rescaling; wide enough that the rounding add cannot overflow
    // for any PAIR_WIDTH up to 128.
    localparam int unsigned WIDE_W = 32'd130;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic  sat;
        wide_t value;
    } narrow_t;

    // Round half up, then arithmetic shift right by shift (shift >= 1).
    function automatic wide_t scale_round(input wide_t x, input int unsigned shift);
        wide_t half;
        half = wide_t'(1'b1) <<< (shift - 32'd1);
        return (x + half) >>> shift;
    endfunction

    // Clamp r into the signed range of out_w bits and flag whether clamping occurred.
    function automatic narrow_t sat_narrow(input wide_t r, input int unsigned out_w);
        wide_t   max_v;
        wide_t   min_v;
        narrow_t res;
        max_v = (wide_t'(1'b1) <<< (out_w - 32'd1)) - wide_t'(1'b1);
        min_v = -(wide_t'(1'b1) <<< (out_w - 32'd1));
        if (r > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (r < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end else begin
            res.value = r;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_l2_pair_fifo.sv
// Synchronous FIFO of {even, odd} output pairs; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module fir_l2_pair_fifo
    import fir_l2_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd128,
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ok_s   = wr_en_i && !full_o && !clear_i;
    assign rd_ok_s   = rd_en_i && !empty_o && !clear_i;

    // Pointer next-state; clear returns both pointers to zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_l2_output_serializer.sv
// L=2 fast-FIR back end: buffers (y[2k], y[2k+1]) pairs, rescales them and emits one sample
// per cycle, even first. Define FIR_L2_SER_SAT_EN for saturating narrowing with a sticky flag.
module fir_l2_output_serializer
    import fir_l2_pkg::*;
#(
    parameter int unsigned PAIR_WIDTH = PAIR_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear_i,
    input  logic                          pair_valid_i,
    output logic                          pair_ready_o,
    input  logic [PAIR_WIDTH-1:0]         pair_even_i,
    input  logic [PAIR_WIDTH-1:0]         pair_odd_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [OUT_WIDTH-1:0]          out_data_o,
    output logic                          out_phase_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          sat_sticky_o
);

    ser_state_e                 state_q;
    ser_state_e                 state_d;
    logic                       out_valid_q;
    logic                       out_valid_d;
    logic [OUT_WIDTH-1:0]       out_data_q;
    logic [OUT_WIDTH-1:0]       out_data_d;
    logic                       out_phase_q;
    logic                       out_phase_d;
    logic [OUT_WIDTH-1:0]       odd_q;
    logic [OUT_WIDTH-1:0]       odd_d;

    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic                       pop_s;
    logic                       hs_s;
    logic [2*PAIR_WIDTH-1:0]    fifo_rd_s;
    logic signed [PAIR_WIDTH-1:0] even_raw_s;
    logic signed [PAIR_WIDTH-1:0] odd_raw_s;
    wide_t                      even_r_s;
    wide_t                      odd_r_s;
    logic [OUT_WIDTH-1:0]       even_scaled_s;
    logic [OUT_WIDTH-1:0]       odd_scaled_s;

    fir_l2_pair_fifo #(
        .WIDTH (2 * PAIR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (clear_i),
        .wr_en_i   (pair_valid_i),
        .wr_data_i ({pair_even_i, pair_odd_i}),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_rd_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .level_o   (fifo_level_o)
    );

    // Ready depends only on registered pointers, never on out_ready_i.
    assign pair_ready_o = !fifo_full_s;
    assign hs_s         = out_valid_q && out_ready_i;
    assign even_raw_s   = signed'(fifo_rd_s[2*PAIR_WIDTH-1:PAIR_WIDTH]);
    assign odd_raw_s    = signed'(fifo_rd_s[PAIR_WIDTH-1:0]);
    assign even_r_s     = scale_round(wide_t'(even_raw_s), SHIFT);
    assign odd_r_s      = scale_round(wide_t'(odd_raw_s), SHIFT);

`ifdef FIR_L2_SER_SAT_EN
    narrow_t even_n_s;
    narrow_t odd_n_s;
    logic    sat_sticky_q;
    logic    sat_sticky_d;
    logic    unused_bits_s;

    assign even_n_s      = sat_narrow(even_r_s, OUT_WIDTH);
    assign odd_n_s       = sat_narrow(odd_r_s, OUT_WIDTH);
    assign even_scaled_s = even_n_s.value[OUT_WIDTH-1:0];
    assign odd_scaled_s  = odd_n_s.value[OUT_WIDTH-1:0];
    assign unused_bits_s = ^{even_n_s.value[WIDE_W-1:OUT_WIDTH], odd_n_s.value[WIDE_W-1:OUT_WIDTH]};
    assign sat_sticky_o  = sat_sticky_q;

    // Sticky flag accumulates clamps of samples entering the output stage.
    always_comb begin
        sat_sticky_d = sat_sticky_q;
        if (clear_i) begin
            sat_sticky_d = 1'b0;
        end else if (pop_s && (even_n_s.sat || odd_n_s.sat)) begin
            sat_sticky_d = 1'b1;
        end else begin
            sat_sticky_d = sat_sticky_q;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_sticky_q <= 1'b0;
        end else begin
            sat_sticky_q <= sat_sticky_d;
        end
    end
`else
    logic unused_bits_s;

    // Without saturation the low bits wrap in two's complement.
    assign even_scaled_s = even_r_s[OUT_WIDTH-1:0];
    assign odd_scaled_s  = odd_r_s[OUT_WIDTH-1:0];
    assign unused_bits_s = ^{even_r_s[WIDE_W-1:OUT_WIDTH], odd_r_s[WIDE_W-1:OUT_WIDTH]};
    assign sat_sticky_o  = 1'b0;
`endif

    // Serializer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ODD chains straight into EVEN when another pair is waiting.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) state_d = ST_EVEN;
                    else               state_d = ST_IDLE;
                end
                ST_EVEN: begin
                    if (hs_s) state_d = ST_ODD;
                    else      state_d = ST_EVEN;
                end
                ST_ODD: begin
                    if (hs_s && !fifo_empty_s)   state_d = ST_EVEN;
                    else if (hs_s)               state_d = ST_IDLE;
                    else                         state_d = ST_ODD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output-stage next values, FIFO pop decision and scaled-pair load.
    always_comb begin
        pop_s       = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_phase_d = out_phase_q;
        odd_d       = odd_q;
        if (clear_i) begin
            out_valid_d = 1'b0;
            out_phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pop_s = !fifo_empty_s;
                end
                ST_EVEN: begin
                    if (hs_s) begin
                        out_data_d  = odd_q;
                        out_phase_d = 1'b1;
                    end else begin
                        out_phase_d = 1'b0;
                    end
                end
                ST_ODD: begin
                    if (hs_s && !fifo_empty_s) begin
                        pop_s = 1'b1;
                    end else if (hs_s) begin
                        out_valid_d = 1'b0;
                        out_phase_d = 1'b0;
                    end else begin
                        out_phase_d = 1'b1;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    out_phase_d = 1'b0;
                end
            endcase
            if (pop_s) begin
                out_valid_d = 1'b1;
                out_data_d  = even_scaled_s;
                out_phase_d = 1'b0;
                odd_d       = odd_scaled_s;
            end else begin
                odd_d = odd_q;
            end
        end
    end

    // Output-stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= 1'b0;
            odd_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_phase_q <= out_phase_d;
            odd_q       <= odd_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_phase_o = out_phase_q;

endmodule
